irq_vec_encoder: RTL and testbench
==================================

Name: irq_vec_encoder

Overview:
Sequential 32-to-5 request encoder, the inverse of the 5-to-32 enable decoder used on the CPU side.
- Captures rising edges on 32 request lines into a pending register.
- Selects one unmasked pending request by priority and presents its 5-bit index with a Valid/Ack handshake.
- Clears the pending bit on acknowledge.
- Sits between peripheral/exception sources and the CPU control unit, which uses Idx as an interrupt/exception vector number.

Parameters:
N, 32, number of request lines
W, 5, index width; must equal clog2(N)

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  asynchronous, active-high reset
Req  input  N  request lines, level; a 0->1 transition posts a request
Mask  input  N  1 = line enabled for selection; 0 = held pending but not selected
En  input  1  global enable for granting
Ack  input  1  consumer accepts the presented index
Valid  output  1  Idx holds a granted request
Idx  output  W  granted request index
Pending  output  N  current pending register, for status reads

Behaviour:
- Reset (async, Rst=1) clears Pending, Req_q, Valid, Idx, the RR pointer, and sets state IDLE. This applies immediately, including mid-handshake.
- Edge capture: Req_q <= Req every cycle. Pending[i] sets at an edge where Req[i]=1 and Req_q[i]=0.
  - A line already high when reset releases is captured at the first edge.
  - A held-high line posts only once.
- Selection set S = Pending & Mask. Fixed priority: the lowest index wins (bit 0 is most urgent).
- FSM IDLE:
  - If En=1 and S!=0: Idx <= winner, Valid <= 1, go to GRANT.
  - Otherwise stay, with Valid=0.
- FSM GRANT:
  - Valid=1; Idx is held stable.
  - Mask changes and new requests do not retract or change Idx.
  - Ack=1 at an edge: Pending[Idx] clears, Valid <= 0, go to IDLE.
  - En=0 at an edge with Ack=0: abort, Valid <= 0, go to IDLE, Pending retained.
  - Ack and En=0 at the same edge: Ack wins.
- Latency:
  - Req rises before edge k: Pending set after k, Valid=1 after k+1.
  - Ack at edge m: the next grant is earliest after m+1 (one bubble cycle, Valid=0 for at least one cycle between grants).
- Simultaneous set and clear of the same bit at one edge: set wins, so the bit stays pending.
- Ack while Valid=0 is ignored.
- All N pending is legal; there is no overflow, and repeated edges on a line already pending are merged.
- Idx holds its last value when Valid=0; it is zero only after reset.

Optional Feature:
- Macro: IRQ_VEC_ROUND_ROBIN_EN.
- Defined:
  - Rotating priority: the search starts at (RR + 1) mod N and wraps 31->0.
  - RR <= Idx on each Ack; an abort does not update RR.
  - Reset RR=N-1, so the first search starts at index 0.
- Undefined: fixed lowest-index priority; the RR register and its logic are not built.

Decomposition:
- Package irq_vec_pkg:
  - N, W constants.
  - State enum {IDLE, GRANT}.
  - First-set-bit function returning W bits plus a found flag.
- Sub-module pri_enc32: combinational priority encoder.
  - Inputs: N-bit vector, W-bit start offset (tied 0 without round-robin).
  - Outputs: W-bit index, found.
  - Instantiated once.

Test Plan:
- Reset mid-GRANT (Req[3] pending, Valid=1), assert Rst -> Valid=0, Pending=0, Idx=0 immediately; after release with Req[3] still high, Pending[3]=1 at the first edge.
- Req[5], Req[9], Req[20] rise together, Mask=all 1, En=1 -> Valid two edges later with Idx=5. Then:
  - Ack -> bubble cycle, Idx=9.
  - Ack -> bubble cycle, Idx=20.
  - Ack -> Pending=0.
- Mask[2]=0, Req[2] and Req[7] rise -> Idx=7 and Pending[2] stays 1; set Mask[2]=1 after the Ack of 7 -> Idx=2.
- In GRANT with Idx=4:
  - Req[1] rises -> Idx stays 4 until Ack.
  - Then deassert En for one edge without Ack -> Valid=0, Pending[4] stays 1.
  - Reassert En -> Idx=1 granted first.
- In GRANT on Idx=6, Req[6] re-rises on the same edge as Ack -> Pending[6]=1 afterwards and 6 is granted again.
- With IRQ_VEC_ROUND_ROBIN_EN: Req[0] and Req[31] held pending, re-posted after each grant -> grants alternate 0, 31, 0, 31. Without the macro -> 0 every time.

Source files
------------

// File: rtl/irq_vec_pkg.sv
// Shared constants, FSM state type and first-set-bit helper for the
// 32-to-5 interrupt/exception request encoder.
package irq_vec_pkg;

  localparam int N = 32;
  localparam int W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic         found;
    logic [W-1:0] idx;
  } fsb_t;

  // Lowest set bit wins; the descending scan leaves the smallest index last.
  function automatic fsb_t first_set(input logic [N-1:0] v);
    fsb_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        r.found = 1'b1;
        r.idx   = W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_vec_encoder_if.sv
// Request/grant bundle between interrupt sources, the encoder and the CPU
// control unit. master = sources/consumer side, slave = the encoder.
interface irq_vec_if;
  import irq_vec_pkg::*;

  logic [N-1:0] Req;
  logic [N-1:0] Mask;
  logic         En;
  logic         Ack;
  logic         Valid;
  logic [W-1:0] Idx;
  logic [N-1:0] Pending;

  modport master (
    output Req, Mask, En, Ack,
    input  Valid, Idx, Pending
  );

  modport slave (
    input  Req, Mask, En, Ack,
    output Valid, Idx, Pending
  );

endinterface

// File: rtl/pri_enc32.sv
// Combinational 32-input priority encoder with a rotating start offset;
// the search begins at start_i and wraps from N-1 back to 0.
module pri_enc32
  import irq_vec_pkg::*;
(
  input  logic [N-1:0] vec_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  logic [N-1:0] rot;
  logic [W-1:0] src;
  fsb_t         fs;

  // rot[i] holds vec_i[(i + start_i) mod N]; W-bit addition wraps for free.
  always_comb begin
    rot = '0;
    src = '0;
    for (int i = 0; i < N; i++) begin
      src    = W'(i) + start_i;
      rot[i] = vec_i[src];
    end
  end

  assign fs      = first_set(rot);
  assign found_o = fs.found;
  assign idx_o   = fs.idx + start_i;

endmodule

// File: rtl/irq_vec_encoder.sv
// Edge-capturing 32-to-5 request encoder with Valid/Ack grant handshake.
// Define IRQ_VEC_ROUND_ROBIN_EN for rotating priority; default is lowest index first.
module irq_vec_encoder
  import irq_vec_pkg::*;
(
  input  logic      Clk,
  input  logic      Rst,
  irq_vec_if.slave  bus
);

  state_t       state_q, state_d;
  logic [N-1:0] req_q, req_d;
  logic [N-1:0] pending_q, pending_d;
  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;

  logic [N-1:0] sel;
  logic [W-1:0] start;
  logic [W-1:0] win_idx;
  logic         win_found;

  assign sel = pending_q & bus.Mask;

`ifdef IRQ_VEC_ROUND_ROBIN_EN
  logic [W-1:0] rr_q, rr_d;
  assign start = rr_q + 1'b1;
`else
  assign start = '0;
`endif

  pri_enc32 u_pri_enc (
    .vec_i   (sel),
    .start_i (start),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = bus.Req;
    pending_d = pending_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
`ifdef IRQ_VEC_ROUND_ROBIN_EN
    rr_d      = rr_q;
`endif
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (bus.En && win_found) begin
          idx_d   = win_idx;
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (bus.Ack) begin
          pending_d[idx_q] = 1'b0;
          valid_d          = 1'b0;
          state_d          = IDLE;
`ifdef IRQ_VEC_ROUND_ROBIN_EN
          rr_d             = idx_q;
`endif
        end else if (!bus.En) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    // New edges are merged after the clear so a same-edge re-post survives.
    pending_d = pending_d | (bus.Req & ~req_q);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
`ifdef IRQ_VEC_ROUND_ROBIN_EN
      rr_q      <= W'(N - 1);
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
`ifdef IRQ_VEC_ROUND_ROBIN_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign bus.Valid   = valid_q;
  assign bus.Idx     = idx_q;
  assign bus.Pending = pending_q;

endmodule

// File: tb/tb_irq_vec_encoder.sv
// Directed bench for irq_vec_encoder; expected values are hand-computed and
// switch with IRQ_VEC_ROUND_ROBIN_EN where priority order differs.
module tb_irq_vec_encoder;
  import irq_vec_pkg::*;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   tests = 0;
  int   failed = 0;

  irq_vec_if bus ();

  irq_vec_encoder dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus.Req = '0;
    bus.Ack = 1'b0;
    bus.En  = 1'b1;
    Rst     = 1'b1;
    #2;
    Rst     = 1'b0;
    tick();
  endtask

  task automatic ack_once();
    bus.Ack = 1'b1;
    tick();
    bus.Ack = 1'b0;
  endtask

  logic [W-1:0] rr_exp [4];

  initial begin
    bus.Req  = '0;
    bus.Mask = '1;
    bus.En   = 1'b1;
    bus.Ack  = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(bus.Valid), 0);
    chk("rst_idx", 32'(bus.Idx), 0);
    chk("rst_pending", bus.Pending, 0);
    Rst = 1'b0;
    tick();

    // Reset in the middle of a grant
    bus.Req[3] = 1'b1;
    tick();
    chk("t1_pend_set", bus.Pending, 32'h8);
    chk("t1_valid_early", 32'(bus.Valid), 0);
    tick();
    chk("t1_valid", 32'(bus.Valid), 1);
    chk("t1_idx", 32'(bus.Idx), 3);
    Rst = 1'b1;
    #1;
    chk("t1_async_valid", 32'(bus.Valid), 0);
    chk("t1_async_pend", bus.Pending, 0);
    chk("t1_async_idx", 32'(bus.Idx), 0);
    Rst = 1'b0;
    tick();
    chk("t1_recapture", bus.Pending, 32'h8);
    tick();
    chk("t1_regrant", 32'({bus.Valid, bus.Idx}), 32'h23);
    ack_once();
    chk("t1_cleared", bus.Pending, 0);
    chk("t1_ack_valid", 32'(bus.Valid), 0);
    tick();
    chk("t1_once_only", bus.Pending, 0);
    bus.Req = '0;
    tick();

    // Three simultaneous requests drained in order
    bus.Req = (32'h1 << 5) | (32'h1 << 9) | (32'h1 << 20);
    tick();
    chk("t2_pend", bus.Pending, 32'h0010_0220);
    chk("t2_valid0", 32'(bus.Valid), 0);
    tick();
    chk("t2_g5", 32'({bus.Valid, bus.Idx}), 32'h25);
    ack_once();
    chk("t2_bubble1", 32'(bus.Valid), 0);
    chk("t2_pend1", bus.Pending, 32'h0010_0200);
    tick();
    chk("t2_g9", 32'({bus.Valid, bus.Idx}), 32'h29);
    ack_once();
    chk("t2_bubble2", 32'(bus.Valid), 0);
    chk("t2_idx_hold", 32'(bus.Idx), 9);
    tick();
    chk("t2_g20", 32'({bus.Valid, bus.Idx}), 32'h34);
    ack_once();
    chk("t2_empty", bus.Pending, 0);
    chk("t2_valid_end", 32'(bus.Valid), 0);
    bus.Req = '0;
    tick();

    // Masked line stays pending until unmasked
    bus.Mask    = '1;
    bus.Mask[2] = 1'b0;
    bus.Req     = (32'h1 << 2) | (32'h1 << 7);
    tick();
    tick();
    chk("t3_g7", 32'({bus.Valid, bus.Idx}), 32'h27);
    ack_once();
    chk("t3_pend2", bus.Pending, 32'h4);
    bus.Mask = '1;
    tick();
    chk("t3_g2", 32'({bus.Valid, bus.Idx}), 32'h22);
    ack_once();
    chk("t3_empty", bus.Pending, 0);
    bus.Req = '0;
    tick();

    // Grant holds against new requests; abort keeps pending
    do_reset();
    bus.Req[4] = 1'b1;
    tick();
    tick();
    chk("t4_g4", 32'({bus.Valid, bus.Idx}), 32'h24);
    bus.Req[1] = 1'b1;
    tick();
    chk("t4_hold", 32'({bus.Valid, bus.Idx}), 32'h24);
    chk("t4_pend", bus.Pending, 32'h12);
    bus.En = 1'b0;
    tick();
    chk("t4_abort_valid", 32'(bus.Valid), 0);
    chk("t4_abort_pend", bus.Pending, 32'h12);
    bus.Ack = 1'b1;
    tick();
    bus.Ack = 1'b0;
    chk("t4_stray_ack", bus.Pending, 32'h12);
    chk("t4_disabled", 32'(bus.Valid), 0);
    bus.En = 1'b1;
    tick();
    chk("t4_g1", 32'({bus.Valid, bus.Idx}), 32'h21);
    ack_once();
    tick();
    chk("t4_g4b", 32'({bus.Valid, bus.Idx}), 32'h24);
    ack_once();
    chk("t4_empty", bus.Pending, 0);
    bus.Req = '0;
    tick();

    // Re-post on the Ack edge: set wins over clear
    bus.Req[6] = 1'b1;
    tick();
    tick();
    chk("t5_g6", 32'({bus.Valid, bus.Idx}), 32'h26);
    bus.Req[6] = 1'b0;
    tick();
    chk("t5_hold", 32'({bus.Valid, bus.Idx}), 32'h26);
    bus.Req[6] = 1'b1;
    ack_once();
    chk("t5_setwins", bus.Pending, 32'h40);
    chk("t5_bubble", 32'(bus.Valid), 0);
    tick();
    chk("t5_regrant", 32'({bus.Valid, bus.Idx}), 32'h26);
    ack_once();
    chk("t5_empty", bus.Pending, 0);
    bus.Req = '0;
    tick();

    // Lines 0 and 31 continuously re-posted
`ifdef IRQ_VEC_ROUND_ROBIN_EN
    rr_exp = '{5'd0, 5'd31, 5'd0, 5'd31};
`else
    rr_exp = '{5'd0, 5'd0, 5'd0, 5'd0};
`endif
    do_reset();
    bus.Req = 32'h8000_0001;
    tick();
    tick();
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("t6_grant%0d", g), 32'({bus.Valid, bus.Idx}), 32'({1'b1, rr_exp[g]}));
      bus.Req[rr_exp[g]] = 1'b0;
      tick();
      bus.Req[rr_exp[g]] = 1'b1;
      ack_once();
      chk($sformatf("t6_repost%0d", g), bus.Pending, 32'h8000_0001);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish within 200000");
    $fatal(1, "timeout");
  end

endmodule
